// File: rtl/run_monitor_pkg.sv
// Package: run_monitor_pkg
// Shared types for the run-control monitor.
//   rm_state_t : run-control FSM state (idle, running, finished by store,
//                finished by cycle-budget expiry)
package run_monitor_pkg;

    typedef enum logic [1:0] {
        RM_IDLE = 2'd0,
        RM_RUN  = 2'd1,
        RM_DONE = 2'd2,
        RM_TOUT = 2'd3
    } rm_state_t;

endpackage

// File: rtl/run_monitor_pc_hit_counter.sv
// Module: pc_hit_counter
// One watched-PC channel: compares pc against watch_pc and counts matches,
// saturating at all-ones.
//   clk      in  1       rising-edge clock
//   rst_n    in  1       asynchronous active-low reset
//   clear    in  1       synchronous clear (run restart)
//   enable   in  1       count only while the run is active
//   pc       in  DATA_W  core program counter
//   watch_pc in  DATA_W  PC to watch on this channel
//   count    out CNT_W   number of cycles pc matched watch_pc
module pc_hit_counter
    import run_monitor_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              enable,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] watch_pc,
    output logic [CNT_W-1:0]  count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (pc == watch_pc) && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/run_monitor.sv
// Module: run_monitor
// Run-control monitor for the mipse core. Counts cycles while running and
// hits on N_WATCH watched PCs; ends the run on a store to FINISH_ADDR
// (capturing the stored data as exit code) or when the cycle budget expires.
//   clk          in  1               rising-edge clock
//   rst_n        in  1               asynchronous active-low reset
//   start        in  1               begin/restart a run (ignored while running)
//   pc           in  DATA_W          core program counter
//   aluresult    in  DATA_W          data-memory address
//   memwrite     in  1               data-memory write enable
//   writedata    in  DATA_W          data-memory write data
//   watch_pc     in  N_WATCH*DATA_W  watched PCs, channel k at [k*DATA_W +: DATA_W]
//   running      out 1               run in progress
//   done         out 1               finished by magic store (sticky)
//   timeout      out 1               finished by budget expiry (sticky)
//   exit_code    out DATA_W          writedata of the finishing store
//   cycle_count  out CNT_W           cycles spent running (wraps)
//   hit_count    out N_WATCH*CNT_W   per-channel hits, channel k at [k*CNT_W +: CNT_W]
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       N_WATCH     = 2,
    parameter int unsigned       CNT_W       = 32,
    parameter logic [DATA_W-1:0] FINISH_ADDR = DATA_W'(32'h7fff),
    parameter int unsigned       MAX_CYCLES  = 100000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [DATA_W-1:0]        pc,
    input  logic [DATA_W-1:0]        aluresult,
    input  logic                     memwrite,
    input  logic [DATA_W-1:0]        writedata,
    input  logic [N_WATCH*DATA_W-1:0] watch_pc,
    output logic                     running,
    output logic                     done,
    output logic                     timeout,
    output logic [DATA_W-1:0]        exit_code,
    output logic [CNT_W-1:0]         cycle_count,
    output logic [N_WATCH*CNT_W-1:0] hit_count
);

    // Budget expires when the cycle being counted is the last allowed one;
    // the normal increment then lands cycle_count exactly on MAX_CYCLES.
    localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);

    rm_state_t state_q, state_d;
    logic      in_run;
    logic      finish;
    logic      budget_hit;
    logic      clear;

    always_comb begin
        in_run     = (state_q == RM_RUN);
        finish     = memwrite && (aluresult == FINISH_ADDR);
        budget_hit = (MAX_CYCLES != 0) && (cycle_count == LAST_CYCLE);
        state_d    = state_q;
        clear      = 1'b0;
        case (state_q)
            RM_RUN: begin
                // finish takes priority over a coincident budget expiry
                if (finish) begin
                    state_d = RM_DONE;
                end else if (budget_hit) begin
                    state_d = RM_TOUT;
                end
            end
            default: begin
                if (start) begin
                    state_d = RM_RUN;
                    clear   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count <= '0;
        end else if (clear) begin
            cycle_count <= '0;
        end else if (in_run) begin
            cycle_count <= cycle_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exit_code <= '0;
        end else if (clear) begin
            exit_code <= '0;
        end else if (in_run && finish) begin
            exit_code <= writedata;
        end
    end

    always_comb begin
        running = (state_q == RM_RUN);
        done    = (state_q == RM_DONE);
        timeout = (state_q == RM_TOUT);
    end

    for (genvar k = 0; k < N_WATCH; k++) begin : g_watch
        pc_hit_counter #(
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W)
        ) u_hit (
            .clk      (clk),
            .rst_n    (rst_n),
            .clear    (clear),
            .enable   (in_run),
            .pc       (pc),
            .watch_pc (watch_pc[k*DATA_W +: DATA_W]),
            .count    (hit_count[k*CNT_W +: CNT_W])
        );
    end

endmodule
